bit_stream_serializer: RTL

Parallel-to-serial source stage that feeds the overlapping sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per `input_pulse` edge, driving the detector's serial data input. A one-entry holding buffer lets a word queue behind the one being shifted, so consecutive words leave with no idle gap between them. Continuous streams matter here: a pattern split across a word boundary must still reach the detector intact.

---
 rtl/bit_stream_serializer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/bit_stream_serializer.sv
// ---------------------------------------------------------------------------
// bit_stream_serializer
//
// Parallel-to-serial source stage for the overlapping sequence detector.
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them out
// one bit per rising edge of input_pulse. A one-entry holding buffer lets
// the next word queue behind the one being shifted. A word offered in the
// last-bit cycle with the buffer empty bypasses straight into the shifter.
// Either path keeps consecutive frames contiguous, so patterns that span a
// word boundary reach the detector intact.
//
// Optional feature macro: SER_PARITY_EN
//   defined   : each frame is WIDTH data bits followed by one even-parity
//               bit (XOR of the data bits); word_done marks the parity bit.
//   undefined : frames are WIDTH data bits; there is no PARITY state.
//
// Parameters
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports
//   input_pulse  in   clock, rising edge active
//   clear        in   asynchronous active-high reset
//   load_valid   in   producer offers load_data
//   load_data    in   word to serialize (held stable while stalled)
//   load_ready   out  holding buffer empty, a word can be accepted
//   ser_bit      out  serial bit (0 when ser_valid is low)
//   ser_valid    out  ser_bit carries a frame bit this cycle
//   busy         out  shifter active
//   word_done    out  final bit of a frame is being presented
// ---------------------------------------------------------------------------
module bit_stream_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             input_pulse,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
  localparam bit HAS_PARITY = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;
`else
  localparam bit HAS_PARITY = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q;
  logic             busy_q;
  logic             word_done_q, word_done_d;

  logic             accept_c;
  logic             frame_end_c;
  logic             start_c;
  logic [WIDTH-1:0] start_word_c;

  // Data bit presented at frame position idx, honouring the bit order.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic [CNT_W-1:0] idx);
    logic [CNT_W-1:0] pos;
    if (MSB_FIRST != 0) begin
      pos = LAST_IDX - idx;
    end else begin
      pos = idx;
    end
    return word[pos];
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    cnt_d        = cnt_q;
    ser_bit_d    = 1'b0;
    word_done_d  = 1'b0;
    start_c      = 1'b0;
    start_word_c = load_data;

    accept_c = load_valid && !hold_full_q;

    // The cycle currently presenting the final bit of the frame.
`ifdef SER_PARITY_EN
    frame_end_c = (state_q == ST_PARITY);
`else
    frame_end_c = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
`endif

    if (frame_end_c) begin
      // A held word wins; hold_full blocks acceptance in this cycle, so a
      // bypass and a drain never compete.
      if (hold_full_q) begin
        start_c      = 1'b1;
        start_word_c = hold_q;
        hold_full_d  = 1'b0;
      end else if (accept_c) begin
        start_c = 1'b1;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          start_c = accept_c;
        end
        ST_SHIFT: begin
          if (accept_c) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
`ifdef SER_PARITY_EN
          if (cnt_q == LAST_IDX) begin
            state_d     = ST_PARITY;
            ser_bit_d   = ^shift_q;
            word_done_d = 1'b1;
          end else
`endif
          begin
            cnt_d       = cnt_q + CNT_W'(1);
            ser_bit_d   = pick_bit(shift_q, cnt_d);
            word_done_d = !HAS_PARITY && (cnt_d == LAST_IDX);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Load a word into the shifter and present its first bit next cycle.
    if (start_c) begin
      state_d     = ST_SHIFT;
      shift_d     = start_word_c;
      cnt_d       = '0;
      ser_bit_d   = pick_bit(start_word_c, CNT_W'(0));
      word_done_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge input_pulse or posedge clear) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= (state_d != ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      word_done_q <= word_done_d;
    end
  end

  assign load_ready = ~hold_full_q;
  assign ser_bit    = ser_bit_q;
  assign ser_valid  = ser_valid_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;

endmodule
